mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

Sequencer and arbiter placing the instruction-fetch (IF) and load/store (LS) ports of the core onto the shared bank-selected SRAM bus (eight 8 KB banks, word-addressed, 1-cycle registered read). It decodes byte addresses into bank select and word index, and checks alignment and range. Byte and halfword stores become read-modify-write sequences, so the SRAM only ever sees full-word accesses. Loads are lane-extracted and sign- or zero-extended.

## Interface
- STARVE_MAX, 3: consecutive IF losses after which IF wins the next contested arbitration.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  combinational accept pulse.
- if_rvalid  out  1  registered one-cycle response pulse.
- if_rdata  out  32  fetched word; valid with if_rvalid.
- if_err  out  1  error flag; valid with if_rvalid.
- ls_req  in  1  load/store request; held with ls_* fields until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  32  byte address.
- ls_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- ls_unsigned  in  1  zero-extend loads.
- ls_wdata  in  32  store data, right-aligned.
- ls_gnt  out  1  combinational accept pulse.
- ls_rvalid  out  1  registered one-cycle response pulse (loads and stores).
- ls_rdata  out  32  load result; valid with ls_rvalid.
- ls_err  out  1  error flag; valid with ls_rvalid.
- sram_en, sram_wen  out  1 each  SRAM enable and write enable.
- sram_cs  out  3  bank select.
- sram_addr  out  11  word index.
- sram_size  out  2  SRAM access size; always 10 (word).
- sram_din  out  32  SRAM write data.
- sram_dout  in  32  SRAM read data; valid the cycle after an en&~wen cycle.

## Operation
- **Address decode:** cs = addr[15:12+1], i.e. addr[15:13]; word index = addr[12:2]; lane = addr[1:0].
- **Errors (no SRAM access):**
  - addr[31:16] ≠ 0;
  - size = 11;
  - halfword with addr[0] = 1;
  - word (including every fetch) with addr[1:0] ≠ 0.
- **FSM states:** IDLE, ERR, RD, MERGE, WR, DATA.
- **IDLE:** grant at most one port per cycle and capture the request into registers.
  - Grant rule: LS wins contention unless starve_cnt == STARVE_MAX, in which case IF wins.
  - starve_cnt increments when IF loses a contested grant and clears when IF is granted.
- **Next state after a grant:**
  - error → ERR;
  - load or fetch → RD;
  - aligned word store → WR;
  - byte or halfword store → RD.
- **RD:** drive sram_en=1, sram_wen=0. Next state: DATA for a load, MERGE for a store.
- **MERGE:** sram_dout is valid. Replace the addressed lane(s) with ls_wdata[7:0] or ls_wdata[15:0], latch the merged word, then go to WR.
- **WR:** drive sram_en=1, sram_wen=1, sram_din = captured word (aligned store) or merged word. Then go to IDLE, with the response registered.
- **DATA:** sram_dout is valid.
  - Byte load: extract sram_dout[8·lane+7 : 8·lane], then sign- or zero-extend.
  - Halfword load: lane 0 or 2, extended the same way.
  - Word load or fetch: pass through.
  - Register rdata and rvalid, then go to IDLE.
- **ERR:** register rvalid=1, err=1, rdata=0, then go to IDLE.
- **Response routing:** responses go to the granted port only; the other port's rvalid stays 0.

## Timing
- Cycle 0 is the gnt cycle. Then:
  - load/fetch: RD in cycle 1, DATA in cycle 2, rvalid in cycle 3;
  - aligned store: WR in cycle 1, rvalid in cycle 2;
  - RMW store: RD 1, MERGE 2, WR 3, rvalid in cycle 4;
  - error: rvalid+err in cycle 2.
- The state is IDLE in the rvalid cycle, so a new gnt may coincide with rvalid.
- At most one transaction is outstanding across both ports. No gnt is issued outside IDLE.
- Outside RD and WR: sram_en=0, sram_wen=0. sram_addr, sram_cs, sram_din and sram_size hold their captured values (size is always 10).
- **Reset (asserted at any time, including mid-transaction):**
  - all outputs 0, FSM to IDLE, starve_cnt 0;
  - the in-flight transaction is dropped, with no rvalid and no partial write beyond a WR already clocked.

## Structure
- Package mem_pkg: FSM state encoding; size codes SZ_B/SZ_H/SZ_W; field positions CS_HI=15, CS_LO=13, WIDX_HI=12, WIDX_LO=2.
- One sub-module, mem_lane_align (combinational), with two functions:
  - load extract/extend: word, lane, size, unsigned → rdata;
  - store merge: word, lane, size, wdata → merged word.

## Test plan
- **Load byte:** SRAM word 0x80FF1234 at cs=1, idx=5. ls load byte at 0x00002015, signed → ls_rvalid in cycle 3 with 0x00000012. Unsigned at 0x00002017 → 0x00000080. Signed at 0x00002017 → 0xFFFFFF80.
- **Halfword store (RMW):** at 0x00000006 with wdata 0xAAAABEEF over 0x11223344 → sequence RD, WR; word becomes 0xBEEF3344; ls_rvalid in cycle 4.
- **Contention:** if_req and ls_req both held for 5 transactions, STARVE_MAX=3 → grant order LS, LS, LS, IF, LS.
- **Errors:** fetch at 0x00000002, half at 0x00000003, any access at 0x00010000 → err=1, no sram_en, rvalid in cycle 2.
- **Reset mid-RMW:** rst_n low in MERGE → no WR issued, no rvalid, all outputs 0; the next request is serviced normally.
- **Back-to-back:** a new ls_req granted in the rvalid cycle of the previous load → the second rvalid arrives exactly 3 cycles later.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the banked SRAM controller: FSM encoding, access-size
// codes, address field positions and the captured-transaction record.
package mem_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERR   = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int CS_HI   = 15;
  localparam int CS_LO   = 13;
  localparam int WIDX_HI = 12;
  localparam int WIDX_LO = 2;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  typedef struct packed {
    port_e      port;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } txn_t;

  // Out-of-window, illegal size or misaligned accesses never reach the SRAM.
  function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] size);
    logic e;
    e = (addr[31:16] != 16'h0000);
    case (size)
      SZ_B:    e = e;
      SZ_H:    e = e | addr[0];
      SZ_W:    e = e | (addr[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling between the 32-bit SRAM word and the LS port:
// load extraction with sign/zero extension, and store-data merge for RMW.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_B:    return uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] m;
    m = w;
    case (size)
      SZ_B: m[{lane, 3'b000} +: 8] = wd[7:0];
      SZ_H: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign rdata_o  = load_extract(word_i, lane_i, size_i, unsigned_i);
  assign merged_o = store_merge(word_i, lane_i, size_i, wdata_i);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Arbitrates the IF and LS ports onto the banked word-wide SRAM; sub-word
// stores are sequenced as read-modify-write so the SRAM only sees full words.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        sram_en,
  output logic        sram_wen,
  output logic [2:0]  sram_cs,
  output logic [10:0] sram_addr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  txn_t          txn_q, txn_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    cs_q, cs_d;
  logic [10:0]   widx_q, widx_d;
  logic [1:0]    ssize_q, ssize_d;
  logic          if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic          ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  logic        idle, pick_if, resp_v, resp_e;
  logic [31:0] resp_data, load_data, merged, sel_addr, sel_wdata;
  txn_t        sel;

  mem_lane_align u_align (
    .word_i     (sram_dout),
    .lane_i     (txn_q.lane),
    .size_i     (txn_q.size),
    .unsigned_i (txn_q.uns),
    .wdata_i    (data_q),
    .rdata_o    (load_data),
    .merged_o   (merged)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d     = state_q;
    starve_d    = starve_q;
    txn_d       = txn_q;
    data_d      = data_q;
    cs_d        = cs_q;
    widx_d      = widx_q;
    ssize_d     = ssize_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_err_d    = if_err_q;
    ls_err_d    = ls_err_q;
    resp_v      = 1'b0;
    resp_e      = 1'b0;
    resp_data   = 32'h0;

    // Gated by rst_n so the grant pulses are low while reset is held.
    idle    = rst_n && (state_q == ST_IDLE);
    pick_if = if_req && (!ls_req || (starve_q == SW'(STARVE_MAX)));
    if_gnt  = idle && pick_if;
    ls_gnt  = idle && ls_req && !pick_if;

    sel       = '{port: PORT_IF, we: 1'b0, size: SZ_W, uns: 1'b0, lane: if_addr[1:0]};
    sel_addr  = if_addr;
    sel_wdata = 32'h0;
    if (!pick_if) begin
      sel       = '{port: PORT_LS, we: ls_we, size: ls_size, uns: ls_unsigned, lane: ls_addr[1:0]};
      sel_addr  = ls_addr;
      sel_wdata = ls_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (if_gnt || ls_gnt) begin
          if (if_gnt)      starve_d = '0;
          else if (if_req) starve_d = starve_q + SW'(1);
          txn_d = sel;
          if (addr_err(sel_addr, sel.size)) begin
            state_d = ST_ERR;
          end else begin
            cs_d    = sel_addr[CS_HI:CS_LO];
            widx_d  = sel_addr[WIDX_HI:WIDX_LO];
            ssize_d = SZ_W;
            data_d  = sel_wdata;
            state_d = (sel.we && sel.size == SZ_W) ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD:    state_d = txn_q.we ? ST_MERGE : ST_DATA;
      ST_MERGE: begin
        data_d  = merged;
        state_d = ST_WR;
      end
      ST_WR: begin
        resp_v  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DATA: begin
        resp_v    = 1'b1;
        resp_data = load_data;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        resp_v  = 1'b1;
        resp_e  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_v) begin
      if (txn_q.port == PORT_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = resp_data;
        if_err_d    = resp_e;
      end else begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = resp_data;
        ls_err_d    = resp_e;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      txn_q       <= '0;
      data_q      <= 32'h0;
      cs_q        <= 3'h0;
      widx_q      <= 11'h0;
      ssize_q     <= 2'b00;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      txn_q       <= txn_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      widx_q      <= widx_d;
      ssize_q     <= ssize_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign sram_en   = (state_q == ST_RD) || (state_q == ST_WR);
  assign sram_wen  = (state_q == ST_WR);
  assign sram_cs   = cs_q;
  assign sram_addr = widx_q;
  assign sram_size = ssize_q;
  assign sram_din  = data_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: banked SRAM model, byte-level reference memory,
// directed scenarios followed by randomized traffic.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_unsigned, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;
  logic        sram_en, sram_wen;
  logic [2:0]  sram_cs;
  logic [10:0] sram_addr;
  logic [1:0]  sram_size;
  logic [31:0] sram_din, sram_dout;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_cs(sram_cs), .sram_addr(sram_addr),
    .sram_size(sram_size), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  logic [119:0] outs;
  assign outs = {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                 sram_en, sram_wen, sram_cs, sram_addr, sram_size, sram_din};

  // Bank-selected SRAM: {cs, word index} addresses one 32-bit word, 1-cycle read.
  logic [31:0] sram [0:16383];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen) sram[{sram_cs, sram_addr}] <= sram_din;
      else          sram_dout <= sram[{sram_cs, sram_addr}];
    end
  end

  int en_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (sram_en) en_cnt++;
    if (sram_en && sram_wen) wr_cnt++;
  end

  // Reference: flat little-endian byte memory of the 64 KB window.
  logic [7:0] ref_b [0:65535];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit is_if, input bit we_in, input logic [31:0] addr,
                       input logic [1:0] size_in, input bit uns, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit err, output int lat,
                       output int en, output int wr);
    bit         we;
    logic [1:0] size;
    int         nb;
    logic [31:0] v;
    we   = is_if ? 1'b0 : we_in;
    size = is_if ? 2'b10 : size_in;
    nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err  = (addr > 32'h0000_FFFF) || (size == 2'b11) || ((addr % nb) != 0);
    rd = 32'h0; lat = 2; en = 0; wr = 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_b[16'(addr + 32'(i))] = wdata[8*i +: 8];
        lat = (nb == 4) ? 2 : 4;
        en  = (nb == 4) ? 1 : 2;
        wr  = 1;
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[16'(addr + 32'(i))]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        rd  = v;
        lat = 3;
        en  = 1;
      end
    end
  endtask

  // Drives one request from a negedge, waits for its grant and response.
  task automatic xact(input bit is_if, input bit we, input logic [31:0] addr,
                      input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                      input string tag, output logic [31:0] got, output int gwait);
    logic [31:0] exp_rd;
    bit          exp_err, other_seen, rv;
    int          exp_lat, exp_en, exp_wr, en0, wr0, lat;
    model(is_if, we, addr, size, uns, wdata, exp_rd, exp_err, exp_lat, exp_en, exp_wr);
    en0 = en_cnt;
    wr0 = wr_cnt;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_size = size;
      ls_unsigned = uns; ls_wdata = wdata;
    end
    gwait = 0;
    #1;
    while (!(is_if ? if_gnt : ls_gnt) && gwait < 20) begin
      @(negedge clk); #1; gwait++;
    end
    check({tag, " gnt"}, is_if ? if_gnt : ls_gnt, 1);
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0;
    ls_req = 1'b0;
    lat = 1;
    other_seen = 1'b0;
    rv = is_if ? if_rvalid : ls_rvalid;
    while (!rv && lat < 12) begin
      other_seen = other_seen | (is_if ? ls_rvalid : if_rvalid);
      @(negedge clk);
      lat++;
      rv = is_if ? if_rvalid : ls_rvalid;
    end
    other_seen = other_seen | (is_if ? ls_rvalid : if_rvalid);
    got = is_if ? if_rdata : ls_rdata;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, got, exp_rd);
    check({tag, " err"}, is_if ? if_err : ls_err, exp_err);
    check({tag, " other rvalid"}, other_seen, 0);
    check({tag, " sram accesses"}, en_cnt - en0, exp_en);
    check({tag, " sram writes"}, wr_cnt - wr0, exp_wr);
    if (exp_en != 0) check({tag, " sram_size"}, sram_size, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          gw, cyc, n_g, w0;
    bit          seen, both;
    int          order [5];
    int          exp_order [5];

    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_size = 0; ls_unsigned = 0; ls_wdata = 0;
    #1 check("reset outputs", outs, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 1, 32'h0000_2014, 2'b10, 0, 32'h80FF_1234, "preload 2014", got, gw);
    check("preload in bank 1 word 5", sram[{3'd1, 11'd5}], 32'h80FF_1234);
    xact(0, 1, 32'h0000_0004, 2'b10, 0, 32'h1122_3344, "preload 0004", got, gw);

    xact(0, 0, 32'h0000_2015, 2'b00, 0, 0, "lb 2015", got, gw);
    check("lb 2015 value", got, 32'h0000_0012);
    xact(0, 0, 32'h0000_2017, 2'b00, 1, 0, "lbu 2017", got, gw);
    check("lbu 2017 value", got, 32'h0000_0080);
    xact(0, 0, 32'h0000_2017, 2'b00, 0, 0, "lb 2017", got, gw);
    check("lb 2017 value", got, 32'hFFFF_FF80);

    xact(0, 1, 32'h0000_0006, 2'b01, 0, 32'hAAAA_BEEF, "sh 0006", got, gw);
    check("sh 0006 sram word", sram[14'd1], 32'hBEEF_3344);
    xact(0, 0, 32'h0000_0004, 2'b10, 0, 0, "lw 0004", got, gw);
    check("lw 0004 value", got, 32'hBEEF_3344);
    xact(0, 0, 32'h0000_0006, 2'b01, 0, 0, "lh 0006", got, gw);
    check("lh 0006 value", got, 32'hFFFF_BEEF);
    xact(1, 0, 32'h0000_2014, 2'b10, 0, 0, "fetch 2014", got, gw);
    check("fetch 2014 value", got, 32'h80FF_1234);

    xact(1, 0, 32'h0000_0002, 2'b10, 0, 0, "fetch misaligned", got, gw);
    xact(0, 0, 32'h0000_0003, 2'b01, 0, 0, "lh misaligned", got, gw);
    xact(0, 1, 32'h0001_0000, 2'b00, 0, 32'h55, "sb out of range", got, gw);
    xact(0, 0, 32'h0000_0000, 2'b11, 0, 0, "illegal size", got, gw);

    xact(0, 0, 32'h0000_2014, 2'b10, 0, 0, "b2b first", got, gw);
    xact(0, 0, 32'h0000_0004, 2'b10, 0, 0, "b2b second", got, gw);
    check("b2b gnt in rvalid cycle", gw, 0);

    // Reset asserted while the controller sits in the merge step.
    ls_req = 1; ls_we = 1; ls_addr = 32'h0000_2016; ls_size = 2'b01;
    ls_unsigned = 0; ls_wdata = 32'h0000_CAFE;
    #1 check("abort gnt", ls_gnt, 1);
    @(posedge clk);
    @(negedge clk);
    ls_req = 0;
    @(negedge clk);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1 check("outputs in mid-rmw reset", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | ls_rvalid | if_rvalid;
    end
    check("abort no rvalid", seen, 0);
    check("abort no write", wr_cnt - w0, 0);
    xact(0, 0, 32'h0000_2014, 2'b10, 0, 0, "load after abort", got, gw);
    check("load after abort value", got, 32'h80FF_1234);

    // Both ports held: LS wins until IF has lost STARVE_MAX times.
    exp_order = '{0, 0, 0, 1, 0};
    order     = '{2, 2, 2, 2, 2};
    if_req = 1; if_addr = 32'h0000_2014;
    ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0004; ls_size = 2'b10; ls_unsigned = 0;
    n_g = 0; cyc = 0; both = 1'b0;
    while (n_g < 5 && cyc < 100) begin
      #1;
      both = both | (if_gnt & ls_gnt);
      if (if_gnt) begin
        order[n_g] = 1; n_g++;
      end else if (ls_gnt) begin
        order[n_g] = 0; n_g++;
      end
      @(negedge clk);
      cyc++;
    end
    if_req = 0;
    ls_req = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("arb grant %0d (1=IF)", i), order[i], exp_order[i]);
    check("arb single gnt", both, 0);

    for (int i = 0; i < 16; i++) begin
      xact(0, 1, 32'(i * 4), 2'b10, 0, $urandom, $sformatf("fill lo %0d", i), got, gw);
      xact(0, 1, 32'h0000_E000 + 32'(i * 4), 2'b10, 0, $urandom, $sformatf("fill hi %0d", i), got, gw);
    end
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      bit          isif;
      a = ($urandom_range(0, 1) != 0 ? 32'h0000_E000 : 32'h0) + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
      isif = ($urandom_range(0, 3) == 0);
      xact(isif, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom, $sformatf("rnd %0d", i), got, gw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
